// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan decoder: segment patterns
// (bit 6 = a ... bit 0 = g), decimal-point bit position and the scan FSM states.
package seg_pkg;

    localparam int DIGITS_DEFAULT = 4;
    localparam int SEG_DP_BIT     = 0;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } scan_state_e;

endpackage : seg_pkg

// File: rtl/seg_pattern_decode.sv
// Combinational lookup from a 7-bit segment pattern to a hex symbol.
// Only exact matches are valid; every other pattern reports valid_o = 0.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       valid_o,
    output logic [3:0] symbol_o
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        valid_o  = 1'b1;
        symbol_o = 4'h0;
        case (pattern_i)
            SEG_0:   symbol_o = 4'h0;
            SEG_1:   symbol_o = 4'h1;
            SEG_2:   symbol_o = 4'h2;
            SEG_3:   symbol_o = 4'h3;
            SEG_4:   symbol_o = 4'h4;
            SEG_5:   symbol_o = 4'h5;
            SEG_6:   symbol_o = 4'h6;
            SEG_7:   symbol_o = 4'h7;
            SEG_8:   symbol_o = 4'h8;
            SEG_9:   symbol_o = 4'h9;
            SEG_A:   symbol_o = 4'hA;
            SEG_B:   symbol_o = 4'hB;
            SEG_C:   symbol_o = 4'hC;
            SEG_D:   symbol_o = 4'hD;
            SEG_E:   symbol_o = 4'hE;
            SEG_F:   symbol_o = 4'hF;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule : seg_pattern_decode

// File: rtl/seg_scan_decoder.sv
// Observes a multiplexed 7-segment bus and rebuilds the per-digit symbol and dp.
// A capture happens once per stable period; frame_valid marks a full set of digits.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEFAULT,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     com_in,
    output logic [4*DIGITS-1:0]   symbols_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  com_err
);

    localparam int              CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYC);
    localparam logic [CW-1:0]   CNT_PRE = CW'(STABLE_CYC - 1);

    scan_state_e          state_q, state_d;
    logic [7:0]           seg_q;
    logic [DIGITS-1:0]    com_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  symbols_q, symbols_d;
    logic [DIGITS-1:0]    dp_q, dp_d;
    logic [DIGITS-1:0]    err_q, err_d;
    logic [DIGITS-1:0]    seen_q, seen_d, seen_next;
    logic                 frame_q, frame_d;
    logic                 com_err_q, com_err_d;

    logic                 changed;
    logic                 com_in_onehot;
    logic                 com_q_multi;
    logic                 reach;
    logic                 capture;
    logic                 dec_valid;
    logic [3:0]           dec_symbol;

    seg_pattern_decode u_decode (
        .pattern_i (seg_q[7:1]),
        .valid_o   (dec_valid),
        .symbol_o  (dec_symbol)
    );

    assign changed       = (seg_in != seg_q) || (com_in != com_q);
    assign com_in_onehot = (com_in != '0) && ((com_in & (com_in - DIGITS'(1))) == '0);
    assign com_q_multi   = (com_q != '0) && ((com_q & (com_q - DIGITS'(1))) != '0);
    // True on the edge where the stability counter reaches STABLE_CYC.
    assign reach         = !changed && (cnt_q == CNT_PRE);
    assign capture       = (state_q == SETTLE) && reach;
    assign cnt_d         = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));

    // State register
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (changed) begin
            state_d = com_in_onehot ? SETTLE : IDLE;
        end else if (capture) begin
            state_d = CAPTURED;
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        symbols_d = symbols_q;
        dp_d      = dp_q;
        err_d     = err_q;
        seen_d    = seen_q;
        seen_next = seen_q;
        frame_d   = 1'b0;
        com_err_d = (state_q == IDLE) && reach && com_q_multi;
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (com_q[i]) begin
                    symbols_d[4*i +: 4] = dec_valid ? dec_symbol : 4'h0;
                    err_d[i]            = !dec_valid;
                    dp_d[i]             = seg_q[SEG_DP_BIT];
                end
            end
            seen_next = seen_q | com_q;
            if (&seen_next) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q     <= '0;
            com_q     <= '0;
            cnt_q     <= '0;
            symbols_q <= '0;
            dp_q      <= '0;
            err_q     <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            com_err_q <= 1'b0;
        end else begin
            seg_q     <= seg_in;
            com_q     <= com_in;
            cnt_q     <= cnt_d;
            symbols_q <= symbols_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            com_err_q <= com_err_d;
        end
    end

    assign symbols_out = symbols_q;
    assign dp_out      = dp_q;
    assign digit_err   = err_q;
    assign frame_valid = frame_q;
    assign com_err     = com_err_q;

endmodule : seg_scan_decoder

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (DIGITS=4, STABLE_CYC=4): scan, glitch,
// undecodable pattern, multi-hot commons, blank and mid-frame reset.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  com_in;
    logic [15:0] symbols_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        com_err;

    int checks;
    int errors;
    int frame_pulses;
    int frame_idx;
    int com_err_pulses;
    int com_err_idx;

    seg_scan_decoder #(
        .DIGITS     (4),
        .STABLE_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .com_in      (com_in),
        .symbols_out (symbols_out),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .com_err     (com_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply one bus value for n edges, recording pulse counts and the edge index
    // (1 = first edge that samples the value) of the last pulse seen.
    task automatic drive(input logic [7:0] s, input logic [3:0] c, input int n);
        @(negedge clk);
        seg_in = s;
        com_in = c;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                frame_pulses++;
                frame_idx = j;
            end
            if (com_err) begin
                com_err_pulses++;
                com_err_idx = j;
            end
        end
    endtask

    task automatic clear_counts();
        frame_pulses   = 0;
        frame_idx      = 0;
        com_err_pulses = 0;
        com_err_idx    = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_counts();
        rst    = 1'b1;
        seg_in = 8'h00;
        com_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_symbols", symbols_out, 16'h0000);
        check("reset_dp", dp_out, 4'h0);
        check("reset_err", digit_err, 4'h0);
        check("reset_frame", frame_valid, 1'b0);
        check("reset_com_err", com_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Idle, blank bus
        drive(8'h00, 4'b0000, 8);
        check("idle_frame_pulses", frame_pulses, 0);
        check("idle_symbols", symbols_out, 16'h0000);

        // Full scan 0,1,2(dp),3
        clear_counts();
        drive(8'hFC, 4'b0001, 6);
        drive(8'h60, 4'b0010, 6);
        drive(8'hDB, 4'b0100, 6);
        check("scan_no_early_frame", frame_pulses, 0);
        drive(8'hF2, 4'b1000, 6);
        check("scan_symbols", symbols_out, 16'h3210);
        check("scan_dp", dp_out, 4'b0100);
        check("scan_err", digit_err, 4'b0000);
        check("scan_frame_pulses", frame_pulses, 1);
        check("scan_frame_latency", frame_idx, 5);

        // Glitch: 4 held only 3 cycles, then 5 held long enough
        clear_counts();
        drive(8'h66, 4'b0010, 3);
        check("glitch_no_capture", symbols_out, 16'h3210);
        drive(8'hB6, 4'b0010, 6);
        check("glitch_symbols", symbols_out, 16'h3250);
        check("glitch_frame_pulses", frame_pulses, 0);

        // Undecodable pattern then valid F on digit 0
        drive(8'h02, 4'b0001, 6);
        check("undec_symbol", symbols_out[3:0], 4'h0);
        check("undec_err", digit_err, 4'b0001);
        drive(8'h8E, 4'b0001, 6);
        check("f_symbols", symbols_out, 16'h325F);
        check("f_err_cleared", digit_err, 4'b0000);

        // Multi-hot commons
        clear_counts();
        drive(8'hFC, 4'b0011, 6);
        check("multi_com_err_pulses", com_err_pulses, 1);
        check("multi_com_err_latency", com_err_idx, 5);
        check("multi_symbols", symbols_out, 16'h325F);
        check("multi_dp", dp_out, 4'b0100);
        check("multi_frame_pulses", frame_pulses, 0);

        // Blank with segments lit: nothing happens
        drive(8'hFF, 4'b0000, 6);
        check("blank_symbols", symbols_out, 16'h325F);
        check("blank_com_err", com_err_pulses, 1);

        // Mask still holds digits 0,1: digits 2,3 complete a frame
        drive(8'h9E, 4'b0100, 6);
        check("mask_no_frame_yet", frame_pulses, 0);
        drive(8'h7A, 4'b1000, 6);
        check("mask_frame_pulses", frame_pulses, 1);
        check("mask_symbols", symbols_out, 16'hDE5F);
        check("mask_dp", dp_out, 4'b0000);

        // Partial frame, then reset mid-settle
        clear_counts();
        drive(8'hBE, 4'b0001, 6);
        drive(8'hEE, 4'b0010, 6);
        drive(8'h3E, 4'b0100, 6);
        check("partial_symbols", symbols_out, 16'hDBA6);
        check("partial_frame_pulses", frame_pulses, 0);
        drive(8'hF2, 4'b1000, 2);
        @(negedge clk);
        rst    = 1'b1;
        seg_in = 8'h00;
        com_in = 4'h0;
        #1;
        check("midreset_symbols", symbols_out, 16'h0000);
        check("midreset_dp", dp_out, 4'h0);
        check("midreset_frame", frame_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Rescan after reset: exactly one frame, only at digit 3
        clear_counts();
        drive(8'hFC, 4'b0001, 6);
        drive(8'h60, 4'b0010, 6);
        drive(8'hDB, 4'b0100, 6);
        check("rescan_no_early_frame", frame_pulses, 0);
        drive(8'hF2, 4'b1000, 6);
        check("rescan_frame_pulses", frame_pulses, 1);
        check("rescan_frame_latency", frame_idx, 5);
        check("rescan_symbols", symbols_out, 16'h3210);
        check("rescan_dp", dp_out, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan_decoder

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Monitor block that observes a multiplexed, active-high 7-segment display bus (segment lines plus one-hot digit commons) and reconstructs the hex symbol and decimal point shown on each digit. It is the receive side of the symbol-to-segment encoding used by the display path. It sits beside the display driver, or on a captured display bus, and gives self-check logic and the test bench a registered view of what the display actually shows. Captures are gated by a stability filter, and a pulse marks each complete display frame.

## Interface
- DIGITS, 4, number of multiplexed digits (commons); range 1..8.
- STABLE_CYC, 4, consecutive identical samples required before a capture; range 2..255.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- seg_in  input  8  segment lines; seg_in[7:1] = segments a..g (bit 7 = a), seg_in[0] = dp; active-high.
- com_in  input  DIGITS  digit commons; active-high; one-hot selects a digit, all-zero means blank.
- symbols_out  output  4*DIGITS  decoded symbol per digit; digit i at [4i+3:4i].
- dp_out  output  DIGITS  captured decimal point per digit.
- digit_err  output  DIGITS  set when the last capture of digit i had an undecodable pattern.
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the previous pulse.
- com_err  output  1  one-cycle pulse on the first stable sample of a com_in with more than one bit set.

## Operation
- Decode table, seg_in[7:1] to symbol, exact match only:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - Any other 7-bit pattern is undecodable.
- Input stage: seg_in and com_in are registered every cycle into a sample register. A stability counter (width ceil(log2(STABLE_CYC+1))) resets to 0 when the new sample differs from the held sample. Otherwise it increments, saturating at STABLE_CYC.
- FSM states:
  - IDLE: com sample is zero or not one-hot.
  - SETTLE: one-hot com sample, counter below STABLE_CYC.
  - CAPTURED: capture done; waiting for a change.
- FSM transitions:
  - Any sample change returns the FSM to IDLE or SETTLE, according to the new com.
  - SETTLE moves to CAPTURED on the edge where the counter reaches STABLE_CYC.
  - Exactly one capture happens per stable period.
- Capture of digit i (the set com bit):
  - Decodable pattern: symbols_out[i] takes the decoded value and digit_err[i] clears.
  - Undecodable pattern: symbols_out[i] takes 0 and digit_err[i] sets.
  - In both cases dp_out[i] takes seg bit 0 and seen-mask bit i sets.
  - Other digits are unchanged.
- Frame tracking:
  - If the seen mask, including the bit set by the current capture, becomes all ones, frame_valid pulses and the mask clears on that same edge.
  - Recapturing an already-seen digit overwrites its outputs and leaves the mask unchanged.
- Blank (com all-zero): no capture and no error; the counter still runs.
- Multi-hot com: no capture; com_err pulses once when the counter reaches STABLE_CYC.

## Timing
- Reset values:
  - symbols_out = 0, dp_out = 0, digit_err = 0, frame_valid = 0, com_err = 0.
  - Seen mask = 0, counter = 0, FSM = IDLE, sample register = 0.
- Latency: let edge k be the first edge that samples a new, constant input. Per-digit outputs update on edge k+STABLE_CYC. frame_valid and com_err are high during the cycle after that edge.
- If the input changes before edge k+STABLE_CYC, there is no capture and the counter restarts.
- A reset asserted mid-settle or mid-frame clears everything immediately. Partial frames are discarded.
- No output depends combinationally on any input.

## Structure
- Package seg_pkg holds:
  - the 16 segment-pattern constants,
  - SEG_DP_BIT = 0,
  - FSM state typedef (IDLE, SETTLE, CAPTURED),
  - default DIGITS.
- Sub-module seg_pattern_decode: a combinational 7-bit to {valid, symbol[3:0]} lookup. It is instantiated once, on the sample register output.

## Test plan
- Reset then idle: all outputs 0, frame_valid never pulses.
- Scan digits 0..3 with patterns 7E, 30, 6D, 79 (dp=1 on digit 2), each held 6 cycles with STABLE_CYC=4:
  - symbols_out = 16'h3210, dp_out = 4'b0100.
  - frame_valid pulses once, 5 cycles after digit 3 first appears.
- Glitch: hold digit 1 at pattern 33 for 3 cycles, then switch to 5B for 6 cycles → digit 1 = 5 only; the 4 is never captured.
- Undecodable pattern 01 on digit 0 → symbols_out[3:0] = 0 and digit_err[0] = 1. A later capture of 47 → F, with digit_err[0] cleared.
- com_in = 4'b0011 held 6 cycles → a single com_err pulse; no output or mask change.
- Reset asserted after 3 of 4 digits are captured: outputs clear. A full rescan then yields exactly one frame_valid.
